f2i: RTL

//  bfloat16 -> signed fixed-point converter; inverse of the i2f stage.

---
 rtl/f2i.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/f2i.sv
// bfloat16 -> signed Q8.7 fixed-point converter, iterative 1-bit/cycle alignment shifter.
// Optional macro F2I_ROUND_NEAREST_EN: round-to-nearest-even on right shifts (default: truncate).
module f2i #(
    parameter int MAN_WIDTH = 7,
    parameter int EXP_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_i,
    input  logic                 sgn_i,
    input  logic [EXP_WIDTH-1:0] exp_i,
    input  logic [MAN_WIDTH-1:0] mantissa_i,
    output logic [EXP_WIDTH-1:0] parte_intera,
    output logic [MAN_WIDTH-1:0] parte_frazionaria,
    output logic                 valid_o,
    output logic                 ovf_o,
    output logic                 busy_o
);
    localparam int W    = EXP_WIDTH + MAN_WIDTH;
    localparam int KW   = EXP_WIDTH + 2;
    localparam int BIAS = 2**(EXP_WIDTH-1) - 1;
    localparam int NW   = $clog2(MAN_WIDTH + 2);
    localparam logic signed [KW-1:0] BIAS_S = KW'(BIAS);
    localparam logic signed [KW-1:0] K_OVF  = KW'(EXP_WIDTH - 1);
    localparam logic signed [KW-1:0] K_MIN  = KW'(-MAN_WIDTH);
    localparam logic signed [KW-1:0] K_ZERO = KW'(-(MAN_WIDTH + 1));
    localparam logic [W-1:0] SAT_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SAT_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [NW-1:0]  n_q, n_d;
    logic           left_q, left_d;
    logic           sgn_q, sgn_d;
    logic           sat_q, sat_d;
    logic           ovf_pend_q, ovf_pend_d;
    logic [W-1:0]   res_q, res_d;
    logic           valid_q, valid_d;
    logic           ovf_out_q, ovf_out_d;
    logic [W-1:0]   mag;
    logic signed [KW-1:0] k;

`ifdef F2I_ROUND_NEAREST_EN
    logic guard_q, guard_d, sticky_q, sticky_d;
    assign mag = acc_q + W'(guard_q & (sticky_q | acc_q[0]));
`else
    assign mag = acc_q;
`endif

    assign k = $signed({2'b00, exp_i}) - BIAS_S;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        n_d        = n_q;
        left_d     = left_q;
        sgn_d      = sgn_q;
        sat_d      = sat_q;
        ovf_pend_d = ovf_pend_q;
        res_d      = res_q;
        valid_d    = 1'b0;
        ovf_out_d  = 1'b0;
`ifdef F2I_ROUND_NEAREST_EN
        guard_d    = guard_q;
        sticky_d   = sticky_q;
`endif
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    sgn_d      = sgn_i;
                    sat_d      = 1'b0;
                    ovf_pend_d = 1'b0;
                    n_d        = '0;
                    left_d     = ~k[KW-1];
                    acc_d      = {{(W-MAN_WIDTH-1){1'b0}}, 1'b1, mantissa_i};
                    state_d    = DONE;
`ifdef F2I_ROUND_NEAREST_EN
                    guard_d    = 1'b0;
                    sticky_d   = 1'b0;
`endif
                    if (exp_i == '0) begin
                        acc_d = '0;
                    end else if (exp_i == '1) begin
                        sat_d      = 1'b1;
                        ovf_pend_d = 1'b1;
                    end else if (k >= K_OVF) begin
                        // the most negative code is exactly representable
                        sat_d      = 1'b1;
                        ovf_pend_d = !(sgn_i && (k == K_OVF) && (mantissa_i == '0));
                    end else if (k < K_MIN) begin
                        // beyond one position past the LSB nothing survives, not even a round bit
                        if (k < K_ZERO) acc_d = '0;
                        n_d     = NW'(MAN_WIDTH + 1);
                        state_d = SHIFT;
                    end else if (k != '0) begin
                        n_d     = k[KW-1] ? NW'(-k) : NW'(k);
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (left_q) begin
                    acc_d = acc_q << 1;
                end else begin
                    acc_d = acc_q >> 1;
`ifdef F2I_ROUND_NEAREST_EN
                    guard_d  = acc_q[0];
                    sticky_d = sticky_q | guard_q;
`endif
                end
                n_d = n_q - NW'(1);
                if (n_q == NW'(1)) state_d = DONE;
            end
            DONE: begin
                if (sat_q)      res_d = sgn_q ? SAT_NEG : SAT_POS;
                else if (sgn_q) res_d = -mag;
                else            res_d = mag;
                valid_d   = 1'b1;
                ovf_out_d = ovf_pend_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            n_q        <= '0;
            left_q     <= 1'b0;
            sgn_q      <= 1'b0;
            sat_q      <= 1'b0;
            ovf_pend_q <= 1'b0;
            res_q      <= '0;
            valid_q    <= 1'b0;
            ovf_out_q  <= 1'b0;
`ifdef F2I_ROUND_NEAREST_EN
            guard_q    <= 1'b0;
            sticky_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            n_q        <= n_d;
            left_q     <= left_d;
            sgn_q      <= sgn_d;
            sat_q      <= sat_d;
            ovf_pend_q <= ovf_pend_d;
            res_q      <= res_d;
            valid_q    <= valid_d;
            ovf_out_q  <= ovf_out_d;
`ifdef F2I_ROUND_NEAREST_EN
            guard_q    <= guard_d;
            sticky_q   <= sticky_d;
`endif
        end
    end

    assign parte_intera      = res_q[W-1:MAN_WIDTH];
    assign parte_frazionaria = res_q[MAN_WIDTH-1:0];
    assign valid_o           = valid_q;
    assign ovf_o             = ovf_out_q;
    assign busy_o            = (state_q != IDLE);
endmodule
